// File: rtl/check_sum_if.sv
// Interface carrying the capture register and injected byte into check_sum and the
// registered checksum back out to the injector.
interface check_sum_if;
  logic [23:0] shift_reg;
  logic [7:0]  inject_data;
  logic [7:0]  checksum;
  logic        checksum_valid;

  modport master (
    output shift_reg,
    output inject_data,
    input  checksum,
    input  checksum_valid
  );

  modport slave (
    input  shift_reg,
    input  inject_data,
    output checksum,
    output checksum_valid
  );
endinterface

// File: rtl/check_sum.sv
// Checksum generator for the frame-injection path: folds the three captured bytes and
// the injected byte into one registered checksum byte, sampled free-running on clk_in.
module check_sum #(
  parameter int unsigned CHECK_MODE = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  check_sum_if.slave bus
);

  logic [7:0] b0, b1, b2, b3;
  logic [7:0] byte_sum;
  logic [7:0] byte_xor;
  logic [7:0] result;

  assign b0 = bus.shift_reg[23:16];
  assign b1 = bus.shift_reg[15:8];
  assign b2 = bus.shift_reg[7:0];
  assign b3 = bus.inject_data;

  // Carries out of bit 7 are intentionally dropped: the checksum is defined mod 256.
  assign byte_sum = b0 + b1 + b2 + b3;
  assign byte_xor = b0 ^ b1 ^ b2 ^ b3;

  // NOTE: result gets a default before the case so no path through the block leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result = ~byte_sum + 8'd1;
    case (CHECK_MODE)
      1:       result = byte_sum;
      2:       result = byte_xor;
      default: result = ~byte_sum + 8'd1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples its
  // pre-edge inputs, independent of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bus.checksum       <= 8'h00;
      bus.checksum_valid <= 1'b0;
    end else begin
      bus.checksum       <= result;
      bus.checksum_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_check_sum.sv
// Self-checking bench for check_sum: one instance per CHECK_MODE value, directed
// checks followed by random frames compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_check_sum;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  bit   clk_run = 1'b0;

  int total = 0;
  int bad   = 0;

  check_sum_if bus0 ();
  check_sum_if bus1 ();
  check_sum_if bus2 ();
  check_sum_if bus3 ();

  check_sum #(.CHECK_MODE(0)) dut0 (.clk_in(clk_in), .reset(reset), .bus(bus0));
  check_sum #(.CHECK_MODE(1)) dut1 (.clk_in(clk_in), .reset(reset), .bus(bus1));
  check_sum #(.CHECK_MODE(2)) dut2 (.clk_in(clk_in), .reset(reset), .bus(bus2));
  check_sum #(.CHECK_MODE(3)) dut3 (.clk_in(clk_in), .reset(reset), .bus(bus3));

  always begin
    #5;
    if (clk_run) clk_in = ~clk_in;
  end

  logic [7:0] cs [4];
  logic       vld [4];
  assign cs[0] = bus0.checksum;  assign vld[0] = bus0.checksum_valid;
  assign cs[1] = bus1.checksum;  assign vld[1] = bus1.checksum_valid;
  assign cs[2] = bus2.checksum;  assign vld[2] = bus2.checksum_valid;
  assign cs[3] = bus3.checksum;  assign vld[3] = bus3.checksum_valid;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic set_inputs(input logic [23:0] sr, input logic [7:0] inj);
    bus0.shift_reg = sr; bus0.inject_data = inj;
    bus1.shift_reg = sr; bus1.inject_data = inj;
    bus2.shift_reg = sr; bus2.inject_data = inj;
    bus3.shift_reg = sr; bus3.inject_data = inj;
  endtask

  // One rising edge, then sample 1 ns later, well clear of the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: the checksum rules evaluated on integers, reduced mod 256 at the end.
  function automatic logic [7:0] ref_cs(input int mode, input logic [23:0] sr, input logic [7:0] inj);
    int bytes [4];
    int s;
    int x;
    bytes = '{int'(sr[23:16]), int'(sr[15:8]), int'(sr[7:0]), int'(inj)};
    s = 0;
    x = 0;
    for (int i = 0; i < 4; i++) begin
      s = s + bytes[i];
      x = x ^ bytes[i];
    end
    case (mode)
      1:       return 8'(s % 256);
      2:       return 8'(x);
      default: return 8'((256 - (s % 256)) % 256);
    endcase
  endfunction

  task automatic check_all(input string tag, input logic [23:0] sr, input logic [7:0] inj);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_m%0d", tag, m), cs[m], ref_cs(m, sr, inj));
      check($sformatf("%s_vld_m%0d", tag, m), {7'd0, vld[m]}, 8'h01);
    end
  endtask

  initial begin
    logic [23:0] sr;
    logic [7:0]  inj;
    logic [7:0]  s8;

    set_inputs(24'h123456, 8'h2B);

    // Reset with the clock stopped takes effect immediately.
    #1 reset = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rst_cs_m%0d", m), cs[m], 8'h00);
      check($sformatf("rst_vld_m%0d", m), {7'd0, vld[m]}, 8'h00);
    end
    #1 reset = 1'b0;
    #1;
    check("post_release_no_edge_vld", {7'd0, vld[0]}, 8'h00);
    clk_run = 1'b1;

    // Typical frame in every mode.
    step();
    check("typ_m0", cs[0], 8'h39);
    check("typ_m1", cs[1], 8'hC7);
    check("typ_m2", cs[2], 8'h5B);
    check("typ_m3", cs[3], 8'h39);
    check("typ_vld", {7'd0, vld[0]}, 8'h01);
    s8 = 8'h12 + 8'h34 + 8'h56 + 8'h2B + cs[0];
    check("typ_m0_sums_to_zero", s8, 8'h00);

    // Inputs change between edges: output must hold, then follow on the next edge.
    set_inputs(24'h000000, 8'h01);
    #3;
    check("hold_m0", cs[0], 8'h39);
    check("hold_m2", cs[2], 8'h5B);
    step();
    check("next_m0", cs[0], 8'hFF);
    check("next_m1", cs[1], 8'h01);
    check("next_m2", cs[2], 8'h01);

    // Wrap and zero boundaries.
    set_inputs(24'hFFFFFF, 8'hFF);
    step();
    check("ff_m0", cs[0], 8'h04);
    check("ff_m1", cs[1], 8'hFC);
    check("ff_m2", cs[2], 8'h00);
    check("ff_m3", cs[3], 8'h04);
    set_inputs(24'h000000, 8'h00);
    step();
    check("zero_m0", cs[0], 8'h00);
    check("zero_m1", cs[1], 8'h00);
    check("zero_m2", cs[2], 8'h00);

    // Reset pulse between edges, then recompute from current inputs.
    set_inputs(24'h123456, 8'h2B);
    step();
    check("pre_rst_m0", cs[0], 8'h39);
    reset = 1'b1;
    #1;
    check("mid_rst_cs", cs[0], 8'h00);
    check("mid_rst_vld", {7'd0, vld[0]}, 8'h00);
    check("mid_rst_cs_m1", cs[1], 8'h00);
    #1 reset = 1'b0;
    set_inputs(24'hA0B0C0, 8'h0D);
    #1;
    check("after_rst_hold_cs", cs[0], 8'h00);
    step();
    check_all("after_rst", 24'hA0B0C0, 8'h0D);

    // Random frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      sr  = 24'($urandom);
      inj = 8'($urandom);
      set_inputs(sr, inj);
      step();
      check_all($sformatf("rand%0d", i), sr, inj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
